if_prefetch_buffer: RTL
=======================

# if_prefetch_buffer

Instruction prefetch queue between the single-port instruction memory and the pipeline's fetch stage. Owns the fetch PC, issues one sequential instruction read at a time on a req/ack handshake, and buffers returned {pc, instr} pairs in a small FIFO so memory wait states are decoupled from the fetch stage. A redirect from branch resolution flushes the queue, cancels any in-flight response, and restarts fetching at the target.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (0 = reset)
- mem_req  out  1  read request to instruction memory
- mem_addr  out  32  request address, word-aligned
- mem_ack  in  1  response valid; completes the outstanding request
- mem_rdata  in  32  instruction word, valid with mem_ack
- redirect  in  1  flush and restart (branch/jump taken)
- redirect_pc  in  32  restart address, valid with redirect
- out_valid  out  1  head entry available
- out_ready  in  1  fetch stage accepts head entry
- out_pc  out  32  PC of head entry
- out_instr  out  32  instruction of head entry
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- State: fetch_pc (32), outstanding (= mem_req), discard (1), FIFO of DEPTH × 64 bits with rd/wr pointers and count.
- Memory handshake: mem_req and mem_addr are registered; once mem_req = 1, mem_addr is held stable until the cycle mem_ack = 1. At most one request outstanding. mem_ack with mem_req = 0 is ignored.
- push = mem_ack & mem_req & ~discard & ~redirect; writes {mem_addr, mem_rdata}; fetch_pc ← mem_addr + 4.
- pop = out_valid & out_ready & ~redirect.
- count_next = count + push − pop; simultaneous push and pop leaves count unchanged.
- Issue: at an edge where (mem_req = 0 or mem_ack = 1) and count_next < DEPTH, mem_req ← 1, mem_addr ← next fetch address; otherwise if mem_ack = 1, mem_req ← 0. Issuing only with count_next < DEPTH guarantees push never overflows.
- Redirect (highest priority): FIFO cleared (count ← 0, pointers ← 0), fetch_pc ← redirect_pc.
  - mem_req = 1 and mem_ack = 0: discard ← 1; request continues on the old address; its ack is dropped; the request to redirect_pc issues at that ack edge (back-to-back).
  - mem_req = 1 and mem_ack = 1: response dropped; request to redirect_pc issues at the same edge.
  - mem_req = 0: request to redirect_pc issues at the same edge.
  - Redirect while discard = 1: only fetch_pc updates; the later issue uses the newest redirect_pc.
- discard clears on the ack edge it consumes.
- out_valid = (count ≠ 0); out_pc and out_instr show the head entry, don't-care when out_valid = 0.
- Arithmetic: PC + 4 modulo 2^32, wraps 32'hFFFF_FFFC → 32'h0000_0000. Pointers wrap modulo DEPTH. redirect_pc[1:0] is forced to 0.

## Timing
- Reset (asynchronous assert, any cycle including mid-request): mem_req = 0, mem_addr = RESET_PC, out_valid = 0, count = 0, discard = 0, fetch_pc = RESET_PC. Any in-flight response is lost; the memory must tolerate an abandoned request.
- First rising edge after reset release: mem_req = 1, mem_addr = RESET_PC.
- Latency: ack at edge N → out_valid = 1 after edge N (visible in cycle N+1); same-edge next issue gives one instruction per cycle with zero-wait memory.
- Redirect at edge N: out_valid = 0 in cycle N+1; the first post-redirect instruction appears one cycle after its ack.
- Full FIFO with out_ready = 0: mem_req stays 0 until a pop makes count_next < DEPTH, then it issues at that pop edge.

## Test plan
- Zero-wait memory (ack the cycle after each req), out_ready = 1, RESET_PC = 0 → out_pc sequence 0x0, 0x4, 0x8…, one per cycle after first fill; count ≤ 1.
- out_ready = 0, zero-wait memory → count reaches 4, mem_req = 0, mem_addr stays 0x10 idle; raise out_ready for one cycle → pop of 0x0 and request 0x10 issue at the same edge.
- 3-cycle wait memory, redirect to 0x100 one cycle after req(0x8) → FIFO empties, data for 0x8 never appears, next req addr 0x100 issued at the ack edge, first output pc 0x100.
- Redirect to 0x200 in the same cycle as mem_ack for 0x4 and out_ready = 1 → no pop, no push, count = 0 next cycle, mem_addr = 0x200.
- Two redirects (0x300, then 0x400) while one request is outstanding → single issue to 0x400; 0x300 never fetched.
- Reset asserted mid-request with 2 entries queued → outputs at reset values immediately (asynchronously); after release, first req at RESET_PC; a stale mem_ack during reset produces no entry.

Source files
------------

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue: one sequential read in flight, {pc, instr} FIFO; ack-to-out_valid is 1 cycle.
// Backpressure: new reads issue only while the FIFO has room; redirect flushes and cancels any in-flight response.
module if_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       mem_req,
  output logic [31:0]                mem_addr,
  input  logic                       mem_ack,
  input  logic [31:0]                mem_rdata,
  input  logic                       redirect,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t          fifo [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [31:0]     fetch_pc;
  logic            discard;

  logic            push;
  logic            pop;
  logic            slot_free;
  logic            issue;
  logic [CW-1:0]   count_next;
  logic [31:0]     target_pc;
  logic [31:0]     seq_pc;
  logic [31:0]     issue_addr;
  logic [31:0]     fetch_pc_next;

  assign out_valid = (count != '0);
  assign out_pc    = fifo[rd_ptr].pc;
  assign out_instr = fifo[rd_ptr].instr;

  always_comb begin
    push          = mem_ack & mem_req & ~discard & ~redirect;
    pop           = out_valid & out_ready & ~redirect;
    target_pc     = {redirect_pc[31:2], 2'b00};
    seq_pc        = mem_addr + 32'd4;
    count_next    = count;
    if (redirect) count_next = '0;
    else          count_next = count + CW'(push) - CW'(pop);
    fetch_pc_next = fetch_pc;
    if (redirect)  fetch_pc_next = target_pc;
    else if (push) fetch_pc_next = seq_pc;
    // After a discarded ack fetch_pc already holds the newest redirect target.
    issue_addr    = fetch_pc_next;
    slot_free     = ~mem_req | mem_ack;
    issue         = slot_free & (count_next < CW'(DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
      fetch_pc <= RESET_PC;
      discard  <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      fetch_pc <= fetch_pc_next;
      count    <= count_next;
      // While idle, mem_addr tracks the next fetch address so a later issue is ready.
      if (slot_free) begin
        mem_req  <= issue;
        mem_addr <= issue_addr;
      end
      if (redirect && mem_req && !mem_ack) discard <= 1'b1;
      else if (mem_req && mem_ack)         discard <= 1'b0;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= '{pc: mem_addr, instr: mem_rdata};
  end

endmodule
